// File: rtl/dma_cycle_seq.sv
// Multi-channel DMA memory-cycle sequencer: arbitrates request channels and runs
// bursts of SETUP/MREQ/HOLD memory cycles. Define DMA_CYCLE_SEQ_FIXED_PRI_EN for fixed priority.
module dma_cycle_seq #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CH_W    = 1,
    parameter int unsigned BURST_W = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               DSPBAK,
    input  logic               WAIT,
    input  logic [NUM_CH-1:0]  REQ,
    input  logic [BURST_W-1:0] BLEN,
    output logic [NUM_CH-1:0]  GNT,
    output logic [CH_W-1:0]    CH,
    output logic [1:0]         DMC,
    output logic [1:0]         DMCL,
    output logic               MREQL,
    output logic               ST23L,
    output logic               DONE,
    output logic               ABORT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_MREQ  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  gnt_q, gnt_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [1:0]         dmcl_q;
    logic               mreql_q, st23l_q;
    logic [CH_W-1:0]    win;

`ifdef DMA_CYCLE_SEQ_FIXED_PRI_EN
    // Lowest-index set request wins; scan downwards so the last hit is the lowest.
    always_comb begin
        win = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (REQ[i]) win = CH_W'(i);
        end
    end
`else
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] idx;

    // Round-robin from ptr+1; scan farthest-first so the nearest set request wins.
    always_comb begin
        win = '0;
        idx = '0;
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((32'(ptr_q) + k) % NUM_CH);
            if (REQ[idx]) win = idx;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
`ifndef DMA_CYCLE_SEQ_FIXED_PRI_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (DSPBAK && (REQ != '0)) begin
                    state_d = S_SETUP;
                    gnt_d   = NUM_CH'(1) << win;
                    ch_d    = win;
                    cnt_d   = BLEN;
                end
            end
            S_SETUP: begin
                if (!DSPBAK) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    gnt_d   = '0;
                end else if (!WAIT) begin
                    state_d = S_MREQ;
                end
            end
            // A started memory cycle always completes, so DSPBAK is not looked at here.
            S_MREQ: begin
                if (!WAIT) state_d = S_HOLD;
            end
            S_HOLD: begin
                if ((cnt_q != '0) && DSPBAK) begin
                    state_d = S_SETUP;
                    cnt_d   = cnt_q - BURST_W'(1);
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    done_d  = (cnt_q == '0);
                    abort_d = (cnt_q != '0);
`ifndef DMA_CYCLE_SEQ_FIXED_PRI_EN
                    ptr_d   = ch_q;
`endif
                end
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with DMC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            dmcl_q  <= 2'b11;
            mreql_q <= 1'b1;
            st23l_q <= 1'b1;
`ifndef DMA_CYCLE_SEQ_FIXED_PRI_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            dmcl_q  <= ~state_d;
            mreql_q <= (state_d != S_MREQ);
            st23l_q <= !((state_d == S_MREQ) || (state_d == S_HOLD));
`ifndef DMA_CYCLE_SEQ_FIXED_PRI_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign DMC   = state_q;
    assign DMCL  = dmcl_q;
    assign MREQL = mreql_q;
    assign ST23L = st23l_q;
    assign GNT   = gnt_q;
    assign CH    = ch_q;
    assign DONE  = done_q;
    assign ABORT = abort_q;

endmodule

// File: tb/tb_dma_cycle_seq.sv
// Self-checking bench for dma_cycle_seq: per-scenario tasks plus a burst scoreboard.
module tb_dma_cycle_seq;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned CH_W    = 1;
    localparam int unsigned BURST_W = 4;

    logic               clk = 1'b0;
    logic               rst, dspbak, mwait;
    logic [NUM_CH-1:0]  req;
    logic [BURST_W-1:0] blen;
    logic [NUM_CH-1:0]  gnt;
    logic [CH_W-1:0]    ch;
    logic [1:0]         dmc, dmcl;
    logic               mreql, st23l, done, abort;

    dma_cycle_seq #(.NUM_CH(NUM_CH), .CH_W(CH_W), .BURST_W(BURST_W)) dut (
        .CLK(clk), .RESET(rst), .DSPBAK(dspbak), .WAIT(mwait), .REQ(req), .BLEN(blen),
        .GNT(gnt), .CH(ch), .DMC(dmc), .DMCL(dmcl), .MREQL(mreql), .ST23L(st23l),
        .DONE(done), .ABORT(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] gnt;
        logic              done;
        logic              abort;
        int                active;
        int                mreq_low;
        int                pulses;
    } burst_t;

    burst_t      exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_ptr  = 0;

    function automatic logic [NUM_CH-1:0] pick(input logic [NUM_CH-1:0] r, input int unsigned p);
`ifdef DMA_CYCLE_SEQ_FIXED_PRI_EN
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (r[i]) return NUM_CH'(1) << i;
`else
        for (int unsigned k = 1; k <= NUM_CH; k++)
            if (r[(p + k) % NUM_CH]) return NUM_CH'(1) << ((p + k) % NUM_CH);
`endif
        return '0;
    endfunction

    function automatic int unsigned ch_of(input logic [NUM_CH-1:0] g);
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes one burst from first non-IDLE cycle to the return to IDLE.
    task automatic run_burst(input logic [NUM_CH-1:0] req_during, input int drop_bak_at_pulse,
                             input int wait_cycles, output burst_t obs, output bit timeout);
        int   guard = 0;
        int   wait_left = 0;
        bit   wait_done = 0;
        logic prev_mreql = 1'b1;
        obs = '{gnt: '0, done: 1'b0, abort: 1'b0, active: 0, mreq_low: 0, pulses: 0};
        timeout = 1'b0;
        while (dmc == 2'd0 && guard < 50) begin tick(); guard++; end
        if (dmc == 2'd0) begin timeout = 1'b1; return; end
        req = req_during;
        while (dmc != 2'd0 && guard < 200) begin
            obs.active++;
            if (gnt != '0) obs.gnt = gnt;
            if (!mreql) begin
                obs.mreq_low++;
                if (prev_mreql) obs.pulses++;
            end
            prev_mreql = mreql;
            if (dmc == 2'd2 && wait_cycles > 0 && !wait_done) begin
                mwait = 1'b1; wait_left = wait_cycles; wait_done = 1'b1;
            end else if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) mwait = 1'b0;
            end
            if (dmc == 2'd2 && obs.pulses == drop_bak_at_pulse) dspbak = 1'b0;
            tick(); guard++;
        end
        if (dmc != 2'd0) timeout = 1'b1;
        else begin obs.done = done; obs.abort = abort; end
    endtask

    task automatic test_reset();
        rst = 1'b1; dspbak = 1'b0; mwait = 1'b0; req = '0; blen = '0;
        tick(); tick();
        n_checks++; if (dmc !== 2'd0)  begin n_fail++; $display("FAIL reset_dmc got=%0d exp=0", dmc); end
        n_checks++; if (dmcl !== 2'd3) begin n_fail++; $display("FAIL reset_dmcl got=%0d exp=3", dmcl); end
        n_checks++; if (mreql !== 1'b1 || st23l !== 1'b1) begin n_fail++; $display("FAIL reset_strobes got=%b%b exp=11", mreql, st23l); end
        n_checks++; if (gnt !== '0 || ch !== '0) begin n_fail++; $display("FAIL reset_gnt got=%b/%0d exp=0/0", gnt, ch); end
        n_checks++; if (done !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", done, abort); end
        rst = 1'b0;
        tick();
        exp_ptr = 0;
    endtask

    task automatic test_single_beat();
        logic [1:0] seq [4];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        req = 2'b01; blen = '0; mwait = 1'b0; dspbak = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            req = '0;
            n_checks++; if (dmc !== seq[c]) begin n_fail++; $display("FAIL single_dmc c=%0d got=%0d exp=%0d", c, dmc, seq[c]); end
            n_checks++; if (dmcl !== ~seq[c]) begin n_fail++; $display("FAIL single_dmcl c=%0d got=%0d exp=%0d", c, dmcl, ~seq[c]); end
            n_checks++; if (mreql !== (seq[c] != 2'd2)) begin n_fail++; $display("FAIL single_mreql c=%0d got=%b", c, mreql); end
            n_checks++; if (st23l !== (seq[c] < 2'd2)) begin n_fail++; $display("FAIL single_st23l c=%0d got=%b", c, st23l); end
            n_checks++; if (gnt !== ((seq[c] != 2'd0) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL single_gnt c=%0d got=%b", c, gnt); end
            n_checks++; if (done !== (c == 3)) begin n_fail++; $display("FAIL single_done c=%0d got=%b", c, done); end
        end
        exp_ptr = 0;
        tick();
    endtask

    task automatic test_arbitration();
        burst_t           obs, e;
        bit               to;
        logic [NUM_CH-1:0] order [4];
`ifdef DMA_CYCLE_SEQ_FIXED_PRI_EN
        order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        // Lone channel-1 burst first, leaving the round-robin pointer at 1.
        req = 2'b10; blen = '0; dspbak = 1'b1; mwait = 1'b0;
        exp_q.push_back('{gnt: pick(2'b10, exp_ptr), done: 1'b1, abort: 1'b0, active: 3, mreq_low: 1, pulses: 1});
        exp_ptr = ch_of(pick(2'b10, exp_ptr));
        for (int b = 0; b < 5; b++) begin
            if (b == 1) begin req = 2'b11; blen = 4'd2; end
            if (b > 0) begin
                exp_q.push_back('{gnt: order[b-1], done: 1'b1, abort: 1'b0, active: 9, mreq_low: 3, pulses: 3});
                exp_ptr = ch_of(order[b-1]);
            end
            run_burst((b == 0 || b == 4) ? 2'b00 : 2'b11, 0, 0, obs, to);
            if (b == 0) tick();
            e = exp_q.pop_front();
            n_checks++; if (to) begin n_fail++; $display("FAIL arb_timeout burst=%0d got=timeout exp=end", b); end
            n_checks++; if (obs.gnt !== e.gnt) begin n_fail++; $display("FAIL arb_gnt burst=%0d got=%b exp=%b", b, obs.gnt, e.gnt); end
            n_checks++; if (obs.active != e.active) begin n_fail++; $display("FAIL arb_len burst=%0d got=%0d exp=%0d", b, obs.active, e.active); end
            n_checks++; if (obs.pulses != e.pulses || obs.mreq_low != e.mreq_low) begin n_fail++; $display("FAIL arb_mreq burst=%0d got=%0d/%0d exp=%0d/%0d", b, obs.pulses, obs.mreq_low, e.pulses, e.mreq_low); end
            n_checks++; if (obs.done !== e.done || obs.abort !== e.abort) begin n_fail++; $display("FAIL arb_end burst=%0d got=%b%b exp=%b%b", b, obs.done, obs.abort, e.done, e.abort); end
        end
        tick();
    endtask

    task automatic test_wait();
        burst_t obs, e;
        bit     to;
        req = 2'b01; blen = '0; dspbak = 1'b1; mwait = 1'b0;
        exp_q.push_back('{gnt: pick(2'b01, exp_ptr), done: 1'b1, abort: 1'b0, active: 5, mreq_low: 3, pulses: 1});
        exp_ptr = ch_of(pick(2'b01, exp_ptr));
        run_burst(2'b00, 0, 2, obs, to);
        e = exp_q.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL wait_timeout got=timeout exp=end"); end
        n_checks++; if (obs.active != e.active) begin n_fail++; $display("FAIL wait_len got=%0d exp=%0d", obs.active, e.active); end
        n_checks++; if (obs.mreq_low != e.mreq_low || obs.pulses != e.pulses) begin n_fail++; $display("FAIL wait_mreq got=%0d/%0d exp=%0d/%0d", obs.mreq_low, obs.pulses, e.mreq_low, e.pulses); end
        n_checks++; if (obs.done !== e.done || obs.abort !== e.abort || obs.gnt !== e.gnt) begin n_fail++; $display("FAIL wait_end got=%b%b/%b exp=%b%b/%b", obs.done, obs.abort, obs.gnt, e.done, e.abort, e.gnt); end
        mwait = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        burst_t obs, e;
        bit     to;
        req = 2'b01; blen = 4'd3; dspbak = 1'b1; mwait = 1'b0;
        exp_q.push_back('{gnt: pick(2'b01, exp_ptr), done: 1'b0, abort: 1'b1, active: 6, mreq_low: 2, pulses: 2});
        exp_ptr = ch_of(pick(2'b01, exp_ptr));
        run_burst(2'b00, 2, 0, obs, to);
        e = exp_q.pop_front();
        n_checks++; if (to) begin n_fail++; $display("FAIL abort_timeout got=timeout exp=end"); end
        n_checks++; if (obs.active != e.active) begin n_fail++; $display("FAIL abort_len got=%0d exp=%0d", obs.active, e.active); end
        n_checks++; if (obs.pulses != e.pulses) begin n_fail++; $display("FAIL abort_pulses got=%0d exp=%0d", obs.pulses, e.pulses); end
        n_checks++; if (obs.done !== e.done || obs.abort !== e.abort) begin n_fail++; $display("FAIL abort_end got=%b%b exp=%b%b", obs.done, obs.abort, e.done, e.abort); end
        n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL abort_gnt got=%b exp=00", gnt); end
        dspbak = 1'b1;
        tick();
    endtask

    task automatic test_setup_abort();
        req = 2'b01; blen = 4'd1; dspbak = 1'b1; mwait = 1'b0;
        tick();
        n_checks++; if (dmc !== 2'd1) begin n_fail++; $display("FAIL sabort_setup got=%0d exp=1", dmc); end
        mwait = 1'b1; dspbak = 1'b0; req = '0;
        tick();
        n_checks++; if (dmc !== 2'd0 || gnt !== '0) begin n_fail++; $display("FAIL sabort_idle got=%0d/%b exp=0/00", dmc, gnt); end
        n_checks++; if (abort !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL sabort_pulse got=%b%b exp=01", done, abort); end
        mwait = 1'b0; dspbak = 1'b1;
        tick();
        n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL sabort_width got=%b exp=0", abort); end
    endtask

    task automatic test_reset_in_mreq();
        req = 2'b01; blen = '0; dspbak = 1'b1; mwait = 1'b0;
        tick();
        req = '0;
        tick();
        n_checks++; if (dmc !== 2'd2) begin n_fail++; $display("FAIL rmreq_pre got=%0d exp=2", dmc); end
        rst = 1'b1;
        tick();
        n_checks++; if (dmc !== 2'd0 || mreql !== 1'b1 || st23l !== 1'b1) begin n_fail++; $display("FAIL rmreq_state got=%0d/%b%b exp=0/11", dmc, mreql, st23l); end
        n_checks++; if (gnt !== '0 || done !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL rmreq_outs got=%b/%b%b exp=00/00", gnt, done, abort); end
        rst = 1'b0;
        tick();
        n_checks++; if (dmc !== 2'd0 || done !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL rmreq_after got=%0d/%b%b exp=0/00", dmc, done, abort); end
        exp_ptr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_arbitration();
        test_wait();
        test_abort();
        test_setup_abort();
        test_reset_in_mreq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_cycle_seq.md
Name: dma_cycle_seq

Overview:
- Multi-channel DMA memory-cycle sequencer; parametrised successor of the single-channel 4-state DMA memory-cycle controller.
- Arbitrates NUM_CH write-request channels while the DSP bus is granted (DSPBAK).
- Runs bursts of 1..2^BURST_W memory cycles per grant, each cycle going through the 4-state sequence with WAIT stretching.
- Drives registered MREQL/ST23L strobes and exposes state bits DMC/DMCL to the DMA address/data datapath.

Parameters:
- NUM_CH, 2: number of request channels (1..8).
- CH_W, 1: width of the channel index; must satisfy 2^CH_W >= NUM_CH.
- BURST_W, 4: width of the burst-length field; a burst is BLEN+1 beats.

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- DSPBAK  in  1  bus acknowledge; cycles may start only while high.
- WAIT  in  1  memory wait; stalls the SETUP and MREQ states.
- REQ  in  NUM_CH  per-channel write-pending flags, active-high, level-sensitive.
- BLEN  in  BURST_W  burst length minus 1; sampled on grant.
- GNT  out  NUM_CH  one-hot grant, held for the whole burst.
- CH  out  CH_W  binary index of the granted channel.
- DMC  out  2  state code: 0=IDLE, 1=SETUP, 2=MREQ, 3=HOLD.
- DMCL  out  2  bitwise inverse of DMC.
- MREQL  out  1  low exactly while DMC==2.
- ST23L  out  1  low while DMC==2 or DMC==3.
- DONE  out  1  one-cycle pulse when a burst ends normally.
- ABORT  out  1  one-cycle pulse when a burst ends because DSPBAK dropped.

Behaviour:
- Reset values: DMC=0, DMCL=3, MREQL=1, ST23L=1, GNT=0, CH=0, DONE=0, ABORT=0, beat counter=0, round-robin pointer=0.
- All outputs are registered. MREQL and ST23L are decoded from the next state, so they align exactly with DMC and never glitch.
- IDLE -> SETUP when DSPBAK=1 and REQ!=0.
  - On this edge: GNT/CH load the winner and the beat counter loads BLEN.
  - Round-robin: search starts at pointer+1 (mod NUM_CH); the first set REQ wins.
- SETUP:
  - DSPBAK=0 -> IDLE, ABORT=1, GNT cleared.
  - else WAIT=1 -> stay in SETUP.
  - else -> MREQ.
- MREQ: WAIT=1 -> stay; else -> HOLD. DSPBAK is ignored here; a started memory cycle always completes.
- HOLD (always exactly 1 cycle):
  - counter!=0 and DSPBAK=1 -> SETUP, counter decrements, same channel.
  - counter==0 -> IDLE, DONE=1, GNT cleared, pointer := CH.
  - counter!=0 and DSPBAK=0 -> IDLE, ABORT=1, GNT cleared, pointer := CH.
- REQ deasserting mid-burst has no effect; the burst runs to completion. Channel request management is the datapath's job.
- Minimum beat length is 3 cycles (SETUP, MREQ, HOLD); each WAIT cycle adds 1.
- Back-to-back bursts: IDLE is always visited for at least 1 cycle between bursts.
- RESET during any state returns to IDLE on the next edge with all outputs at reset values. No DONE or ABORT pulse is produced.
- Simultaneous events:
  - WAIT and DSPBAK drop in SETUP: abort takes priority.
  - DONE and ABORT are never asserted together.
- Unused REQ bits above NUM_CH do not exist; CH never exceeds NUM_CH-1.

Optional Feature:
- Macro DMA_CYCLE_SEQ_FIXED_PRI_EN.
- Defined: fixed priority, lowest-index set REQ wins; the round-robin pointer is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then DSPBAK=1, REQ=01, BLEN=0, WAIT=0:
  - DMC goes 0,1,2,3,0.
  - MREQL low 1 cycle; ST23L low 2 cycles.
  - DONE pulses on the return to IDLE; GNT=01 for 3 cycles.
- REQ=11, BLEN=2, repeated bursts, round-robin build:
  - GNT order 01,10,01,10.
  - Each burst spans 9 cycles of SETUP/MREQ/HOLD.
- WAIT=1 for 2 cycles entering MREQ, BLEN=0: MREQL stays low 3 cycles; beat length is 5 cycles.
- BLEN=3, DSPBAK dropped during the 2nd beat's MREQ:
  - The beat completes through HOLD, then IDLE.
  - ABORT=1, DONE=0, and only 2 MREQL pulses are seen.
- RESET asserted in the MREQ state: next cycle DMC=0, MREQL=1, ST23L=1, GNT=0, and no DONE/ABORT pulse.
- DMA_CYCLE_SEQ_FIXED_PRI_EN build, REQ=11 held over 3 bursts: GNT=01 every burst.
